// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: detects RAW hazards between ID sources and EXE/MEM destinations
// (full interlock, or load-use only when forwarding is active), freezes the
// whole pipeline for MEM_WAIT cycles per data-memory access, flushes on
// taken branches and counts stalled cycles.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   src1, src2, two_src       ID-stage source registers / src2 is read
//   exe_dest, exe_wb_en,
//   exe_mem_r_en              EXE destination, writeback, load flag
//   mem_dest, mem_wb_en       MEM destination, writeback
//   fwd_en                    forwarding unit active
//   mem_req                   MEM-stage load/store
//   branch_taken              EXE resolves a taken branch
//   hazard                    bubble ID/EXE control
//   freeze_front              hold PC and IF/ID
//   freeze_all                hold PC and every pipeline register
//   flush                     clear IF/ID and ID/EXE
//   sram_start, mem_ready     SRAM access start / completion pulses
//   stall_cnt                 saturating count of stalled cycles

module pipeline_stall_controller #(
  parameter int MEM_WAIT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             two_src,
  input  logic [3:0]       exe_dest,
  input  logic             exe_wb_en,
  input  logic             exe_mem_r_en,
  input  logic [3:0]       mem_dest,
  input  logic             mem_wb_en,
  input  logic             fwd_en,
  input  logic             mem_req,
  input  logic             branch_taken,
  output logic             hazard,
  output logic             freeze_front,
  output logic             freeze_all,
  output logic             flush,
  output logic             sram_start,
  output logic             mem_ready,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int CW = (MEM_WAIT > 2) ? $clog2(MEM_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_WAIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic m_exe1, m_exe2, m_mem1, m_mem2;
  logic raw_hazard;

  // r0 is an ordinary register here, so a match on 4'd0 counts.
  assign m_exe1 = exe_wb_en & (src1 == exe_dest);
  assign m_exe2 = exe_wb_en & two_src & (src2 == exe_dest);
  assign m_mem1 = mem_wb_en & (src1 == mem_dest);
  assign m_mem2 = mem_wb_en & two_src & (src2 == mem_dest);

  // With forwarding only a load in EXE cannot be bypassed in time.
  assign raw_hazard = fwd_en ? (exe_mem_r_en & (m_exe1 | m_exe2))
                             : (m_exe1 | m_exe2 | m_mem1 | m_mem2);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    freeze_all   = 1'b0;
    sram_start   = 1'b0;
    mem_ready    = 1'b0;
    hazard       = 1'b0;
    flush        = 1'b0;
    freeze_front = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_req) begin
          freeze_all = 1'b1;
          sram_start = 1'b1;
          cnt_d      = CNT_LOAD;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        freeze_all = 1'b1;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        // mem_req still reflects the completing instruction; ignore it.
        mem_ready = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A branch held in the frozen EXE register flushes once released;
    // the ID instruction it kills cannot raise a hazard.
    flush        = branch_taken & ~freeze_all;
    hazard       = raw_hazard & ~branch_taken & ~freeze_all;
    freeze_front = hazard | freeze_all;

    if (rst) begin
      freeze_all   = 1'b0;
      sram_start   = 1'b0;
      mem_ready    = 1'b0;
      hazard       = 1'b0;
      flush        = 1'b0;
      freeze_front = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (freeze_front && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - self-checking bench for pipeline_stall_controller

module tb_pipeline_stall_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] src1, src2, exe_dest, mem_dest;
  logic       two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic       fwd_en, mem_req, branch_taken;

  logic        hazard, freeze_front, freeze_all, flush, sram_start, mem_ready;
  logic [15:0] stall_cnt;
  logic        s_hazard, s_freeze_front, s_freeze_all, s_flush, s_sram_start, s_mem_ready;
  logic [3:0]  s_stall_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.MEM_WAIT(4), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
    .mem_req(mem_req), .branch_taken(branch_taken),
    .hazard(hazard), .freeze_front(freeze_front), .freeze_all(freeze_all),
    .flush(flush), .sram_start(sram_start), .mem_ready(mem_ready),
    .stall_cnt(stall_cnt)
  );

  pipeline_stall_controller #(.MEM_WAIT(4), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src),
    .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .fwd_en(fwd_en),
    .mem_req(mem_req), .branch_taken(branch_taken),
    .hazard(s_hazard), .freeze_front(s_freeze_front), .freeze_all(s_freeze_all),
    .flush(s_flush), .sram_start(s_sram_start), .mem_ready(s_mem_ready),
    .stall_cnt(s_stall_cnt)
  );

  typedef struct {
    logic [3:0] src1, src2, exe_dest, mem_dest;
    logic       two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, fwd_en, branch_taken;
    logic       exp_hazard, exp_ff, exp_flush;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    src1 = 4'd1; src2 = 4'd2; exe_dest = 4'd9; mem_dest = 4'd10;
    two_src = 1'b0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_wb_en = 1'b0;
    fwd_en = 1'b0; mem_req = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".hazard"},       32'(hazard),       32'd0);
    chk({tag, ".freeze_front"}, 32'(freeze_front), 32'd0);
    chk({tag, ".freeze_all"},   32'(freeze_all),   32'd0);
    chk({tag, ".flush"},        32'(flush),        32'd0);
    chk({tag, ".sram_start"},   32'(sram_start),   32'd0);
    chk({tag, ".mem_ready"},    32'(mem_ready),    32'd0);
  endtask

  initial begin
    // src1 src2 exe_d mem_d two wb memr mwb fwd br -> hz ff fl
    vecs[0]  = '{4'd3, 4'd2, 4'd3, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{4'd3, 4'd2, 4'd3, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'd1, 4'd5, 4'd9, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd1, 4'd5, 4'd9, 4'd5,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{4'd2, 4'd6, 4'd2, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd2, 4'd6, 4'd2, 4'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{4'd5, 4'd6, 4'd9, 4'd5,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd3, 4'd2, 4'd3, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{4'd0, 4'd2, 4'd0, 4'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{4'd1, 4'd7, 4'd7, 4'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{4'd1, 4'd7, 4'd7, 4'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'd1, 4'd2, 4'd9, 4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset: outputs forced low even with hazard and mem_req present.
    clear_inputs();
    rst = 1'b1;
    mem_req = 1'b1; src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1; branch_taken = 1'b1;
    @(negedge clk); #1;
    chk_all_zero("reset");
    chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset.sat_stall_cnt", 32'(s_stall_cnt), 32'd0);

    // Combinational hazard/flush table in IDLE.
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      src1 = vecs[i].src1; src2 = vecs[i].src2;
      exe_dest = vecs[i].exe_dest; mem_dest = vecs[i].mem_dest;
      two_src = vecs[i].two_src; exe_wb_en = vecs[i].exe_wb_en;
      exe_mem_r_en = vecs[i].exe_mem_r_en; mem_wb_en = vecs[i].mem_wb_en;
      fwd_en = vecs[i].fwd_en; branch_taken = vecs[i].branch_taken;
      #1;
      chk($sformatf("vec%0d.hazard", i),       32'(hazard),       32'(vecs[i].exp_hazard));
      chk($sformatf("vec%0d.freeze_front", i), 32'(freeze_front), 32'(vecs[i].exp_ff));
      chk($sformatf("vec%0d.flush", i),        32'(flush),        32'(vecs[i].exp_flush));
      chk($sformatf("vec%0d.freeze_all", i),   32'(freeze_all),   32'd0);
      chk($sformatf("vec%0d.sram_start", i),   32'(sram_start),   32'd0);
    end

    // Memory access sequence with a deferred branch.
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_req = 1'b1; src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    #1;
    chk("c0.sram_start",   32'(sram_start),   32'd1);
    chk("c0.freeze_all",   32'(freeze_all),   32'd1);
    chk("c0.hazard",       32'(hazard),       32'd0);
    chk("c0.freeze_front", 32'(freeze_front), 32'd1);
    chk("c0.mem_ready",    32'(mem_ready),    32'd0);
    chk("c0.stall_cnt",    32'(stall_cnt),    32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 1) branch_taken = 1'b1;
      #1;
      chk($sformatf("c%0d.freeze_all", c), 32'(freeze_all), 32'd1);
      chk($sformatf("c%0d.sram_start", c), 32'(sram_start), 32'd0);
      chk($sformatf("c%0d.flush", c),      32'(flush),      32'd0);
      chk($sformatf("c%0d.mem_ready", c),  32'(mem_ready),  32'd0);
      chk($sformatf("c%0d.hazard", c),     32'(hazard),     32'd0);
    end
    @(negedge clk); #1;
    chk("c4.freeze_all",   32'(freeze_all),   32'd0);
    chk("c4.mem_ready",    32'(mem_ready),    32'd1);
    chk("c4.flush",        32'(flush),        32'd1);
    chk("c4.hazard",       32'(hazard),       32'd0);
    chk("c4.freeze_front", 32'(freeze_front), 32'd0);
    chk("c4.sram_start",   32'(sram_start),   32'd0);
    chk("c4.stall_cnt",    32'(stall_cnt),    32'd4);
    @(negedge clk);
    branch_taken = 1'b0; exe_wb_en = 1'b0;
    #1;
    chk("c5.sram_start", 32'(sram_start), 32'd1);
    chk("c5.freeze_all", 32'(freeze_all), 32'd1);
    chk("c5.mem_ready",  32'(mem_ready),  32'd0);
    chk("c5.stall_cnt",  32'(stall_cnt),  32'd4);
    @(negedge clk); #1;
    chk("c6.freeze_all", 32'(freeze_all), 32'd1);
    chk("c6.sram_start", 32'(sram_start), 32'd0);

    // Reset in the middle of the second access.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    chk("midrst.stall_cnt", 32'(stall_cnt), 32'd6);
    @(negedge clk);
    rst = 1'b0; mem_req = 1'b0;
    #1;
    chk("postrst.stall_cnt", 32'(stall_cnt), 32'd0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(negedge clk); #1;
      end
      chk($sformatf("postrst%0d.mem_ready", c),  32'(mem_ready),  32'd0);
      chk($sformatf("postrst%0d.freeze_all", c), 32'(freeze_all), 32'd0);
      chk($sformatf("postrst%0d.sram_start", c), 32'(sram_start), 32'd0);
    end

    // Saturation: 20 hazard cycles into a 4-bit counter.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    src1 = 4'd3; exe_dest = 4'd3; exe_wb_en = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    chk("sat.stall_cnt_w16", 32'(stall_cnt),   32'd20);
    chk("sat.stall_cnt_w4",  32'(s_stall_cnt), 32'd15);
    exe_wb_en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("sat.hold_w4",  32'(s_stall_cnt), 32'd15);
    chk("sat.hold_w16", 32'(stall_cnt),   32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Detects RAW hazards between the ID-stage source registers and in-flight EXE/MEM destinations, with a forwarding-aware mode.
- Sequences multi-cycle data-memory (SRAM) accesses by freezing the whole pipeline for a fixed wait count, and issues flushes on taken branches.
- Sits beside the pipeline registers and drives their freeze/flush inputs plus the ID-stage hazard input.

Parameters:
- MEM_WAIT, 4, total cycles the pipeline is frozen per data-memory access; legal range >= 2.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- src1  in  4  ID first source register (Rn).
- src2  in  4  ID second source register (Rm, or Rd for stores).
- two_src  in  1  ID instruction reads src2.
- exe_dest  in  4  destination register of instruction in EXE.
- exe_wb_en  in  1  EXE instruction writes back.
- exe_mem_r_en  in  1  EXE instruction is a load.
- mem_dest  in  4  destination register of instruction in MEM.
- mem_wb_en  in  1  MEM instruction writes back.
- fwd_en  in  1  forwarding unit active.
- mem_req  in  1  MEM-stage instruction is a load or store (MEM_R_EN | MEM_W_EN).
- branch_taken  in  1  EXE resolves a taken branch (B).
- hazard  out  1  to ID stage; bubble the ID/EXE control signals.
- freeze_front  out  1  hold PC and IF/ID register.
- freeze_all  out  1  hold PC and every pipeline register.
- flush  out  1  clear IF/ID and ID/EXE registers.
- sram_start  out  1  one-cycle pulse starting the SRAM access.
- mem_ready  out  1  one-cycle pulse; memory data valid, pipeline released.
- stall_cnt  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- Match terms: m_exe1 = exe_wb_en & (src1==exe_dest); m_exe2 = exe_wb_en & two_src & (src2==exe_dest); m_mem1 and m_mem2 are defined the same way using mem_dest and mem_wb_en.
- raw_hazard when fwd_en=0: m_exe1 | m_exe2 | m_mem1 | m_mem2.
- raw_hazard when fwd_en=1: exe_mem_r_en & (m_exe1 | m_exe2). This is load-use only.
- Memory FSM states: IDLE, ACCESS, DONE. Down-counter cnt is ceil(log2(MEM_WAIT)) bits wide.
- IDLE & mem_req: freeze_all=1, sram_start=1; next state ACCESS; cnt <= MEM_WAIT-1.
- IDLE & !mem_req: stay in IDLE.
- ACCESS: freeze_all=1. If cnt==1, go to DONE; else cnt <= cnt-1.
- DONE: freeze_all=0, mem_ready=1; next state IDLE. mem_req is ignored in DONE, because it still reflects the completing instruction.
- Net effect: freeze_all is high for exactly MEM_WAIT consecutive cycles, then mem_ready pulses for 1 cycle.
- Back-to-back memory ops: the next load/store enters MEM on the DONE edge, is seen in IDLE the following cycle, and a new sequence starts with no gap.
- flush = branch_taken & ~freeze_all.
- hazard = raw_hazard & ~branch_taken & ~freeze_all. Branch beats hazard because the ID instruction is being flushed.
- freeze_front = hazard | freeze_all.
- hazard, freeze_front, freeze_all, flush, sram_start and mem_ready are combinational from inputs and state.
- While rst=1, all six of those outputs are forced to 0.
- stall_cnt increments by 1 on each edge where freeze_front=1. It saturates at 2^CNT_W-1 and does not wrap.
- Reset (synchronous, including mid-ACCESS): state <= IDLE, cnt <= 0, stall_cnt <= 0. No mem_ready is emitted for an aborted access.
- Same-cycle conflicts:
  - A taken branch during freeze_all is deferred. The EXE register is frozen, so branch_taken stays asserted, and flush fires on the DONE cycle.
  - mem_req together with raw_hazard in IDLE: freeze_all wins and hazard=0.
  - Once DONE releases the pipeline, hazard is re-evaluated.
- Register r0 is not special; a match on 4'd0 is a hazard.

Test Plan:
- fwd_en=0, src1=3, exe_dest=3, exe_wb_en=1 -> hazard=1 and freeze_front=1 in the same cycle; change exe_wb_en=0 -> hazard=0.
- fwd_en=0, two_src=0, src2=5, mem_dest=5, mem_wb_en=1 -> hazard=0; set two_src=1 -> hazard=1.
- fwd_en=1, EXE writes r2 with exe_mem_r_en=0, src1=2 -> hazard=0; set exe_mem_r_en=1 -> hazard=1.
- MEM_WAIT=4, mem_req held high -> sram_start pulses at cycle 0; freeze_all=1 for cycles 0-3; mem_ready=1 and freeze_all=0 at cycle 4; new sram_start at cycle 5. A branch_taken asserted at cycle 1 produces flush only at cycle 4. stall_cnt=4 after cycle 4.
- branch_taken=1 together with a matching RAW hazard in IDLE -> flush=1, hazard=0, freeze_front=0.
- Assert rst during ACCESS (cycle 2) -> all outputs 0 while rst=1. After release with mem_req=0: state IDLE, stall_cnt=0, no mem_ready pulse. With CNT_W=4 and 20 hazard cycles, stall_cnt holds at 15.
